// File: rtl/kf8253_pkg.sv
// Purpose: shared encodings and count arithmetic for the 8253 counter channel.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package kf8253_pkg;

  typedef enum logic [2:0] {
    MODE_0 = 3'd0,
    MODE_1 = 3'd1,
    MODE_2 = 3'd2,
    MODE_3 = 3'd3,
    MODE_4 = 3'd4,
    MODE_5 = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_BOTH  = 2'b11
  } rw_t;

  typedef enum logic {
    PTR_LSB = 1'b0,
    PTR_MSB = 1'b1
  } ptr_t;

  // A stored count of zero means the full range (65536 binary, 10000 BCD);
  // decrementing it simply wraps to 0xFFFF / 0x9999.
  localparam logic [15:0] COUNT_ZERO = 16'h0000;
  localparam logic [15:0] COUNT_ONE  = 16'h0001;

  function automatic logic [15:0] bin_dec16(input logic [15:0] v);
    return v - 16'd1;
  endfunction

  // Four-digit BCD decrement: each nibble borrows from the next, 0000 -> 9999.
  function automatic logic [15:0] bcd_dec16(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] dec16(input logic [15:0] v, input logic bcd);
    return bcd ? bcd_dec16(v) : bin_dec16(v);
  endfunction

endpackage

// File: rtl/kf8253_pin_sync.sv
// Purpose: synchronise the CLKn/GATEn pins and flag falling edges of CLKn.
// Latency: count_edge asserts SYNC_STAGES system clocks after the pin falls.
// Backpressure: none; every detected edge is presented for exactly one cycle.
module kf8253_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic counter_clock,
  input  logic counter_gate,
  output logic count_edge,
  output logic gate_sync
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] gate_sync_q;
  logic                   clk_hist;

  // Synchroniser chains plus one history flop on the clock path for edge detect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync    <= '0;
      gate_sync_q <= '0;
      clk_hist    <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], counter_clock};
      gate_sync_q <= {gate_sync_q[SYNC_STAGES-2:0], counter_gate};
      clk_hist    <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign count_edge = clk_hist & ~clk_sync[SYNC_STAGES-1];
  assign gate_sync  = gate_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/kf8253_counter_channel.sv
// Purpose: one 8253 counter channel: count register, count element, output latch, OUT pin.
// Latency: count element updates one system clock after a synchronised CLKn fall; OUT registered.
// Backpressure: none; write strobes are single-cycle and always accepted, reads are combinational.
module kf8253_counter_channel
  import kf8253_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] internal_data_bus,
  input  logic       write_control,
  input  logic       write_counter,
  input  logic       read_counter,
  output logic [7:0] read_data,
  input  logic       counter_clock,
  input  logic       counter_gate,
  output logic       counter_out
);

  mode_t       mode;
  rw_t         rw;
  logic        bcd;
  logic [15:0] count_reg;
  logic [15:0] count;
  logic [15:0] latch;
  logic        latched;
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  logic        null_count;
  logic        load_pending;
  logic        gate_d;
  logic        read_counter_d;

  logic        count_edge;
  logic        gate_sync;

  kf8253_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clock        (clock),
    .reset_n      (reset_n),
    .counter_clock(counter_clock),
    .counter_gate (counter_gate),
    .count_edge   (count_edge),
    .gate_sync    (gate_sync)
  );

  // Control word fields; modes 6/7 alias 2/3.
  logic [2:0] cw_mode_raw;
  mode_t      cw_mode;
  rw_t        cw_rw;
  assign cw_mode_raw = internal_data_bus[3:1];
  assign cw_mode     = mode_t'((cw_mode_raw[2:1] == 2'b11) ? {1'b0, cw_mode_raw[1:0]} : cw_mode_raw);
  assign cw_rw       = rw_t'(internal_data_bus[5:4]);

  logic mode_ok;
  logic mode_23;
  logic halt;
  logic read_fall;
  assign mode_ok   = (mode == MODE_0) || (mode == MODE_2) || (mode == MODE_3) || (mode == MODE_4);
  assign mode_23   = (mode == MODE_2) || (mode == MODE_3);
  // Mode 0 freezes between the two halves of a 16-bit count write.
  assign halt      = (mode == MODE_0) && (rw == RW_BOTH) && (wr_ptr == PTR_MSB);
  assign read_fall = read_counter_d & ~read_counter;

  logic [15:0] dec1;
  logic [15:0] dec2;
  logic [15:0] dec3;
  assign dec1 = dec16(count, bcd);
  assign dec2 = dec16(dec1, bcd);
  assign dec3 = dec16(dec2, bcd);

  // Mode 3 step: odd counts only occur right after a reload, and absorb the odd unit
  // in the high half (step 1) or the low half (step 3); everything else steps by 2.
  logic [15:0] m3_step;
  logic [15:0] m3_next;
  logic        m3_zero;
  always_comb begin
    m3_step = 16'd2;
    m3_next = dec2;
    if (count[0]) begin
      m3_step = counter_out ? 16'd1 : 16'd3;
      m3_next = counter_out ? dec1 : dec3;
    end
  end
  assign m3_zero = (count != COUNT_ZERO) && (count <= m3_step);

  // Configuration, count register writes, count element and OUT pin
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode         <= MODE_0;
      rw           <= RW_LSB;
      bcd          <= 1'b0;
      count_reg    <= 16'h0000;
      count        <= 16'h0000;
      wr_ptr       <= PTR_LSB;
      null_count   <= 1'b1;
      load_pending <= 1'b0;
      counter_out  <= 1'b0;
      gate_d       <= 1'b0;
    end else begin
      gate_d <= gate_sync;
      if (write_control) begin
        if (cw_rw != RW_LATCH) begin
          mode         <= cw_mode;
          rw           <= cw_rw;
          bcd          <= internal_data_bus[0];
          wr_ptr       <= PTR_LSB;
          null_count   <= 1'b1;
          load_pending <= 1'b0;
          counter_out  <= (cw_mode != MODE_0);
        end
      end else begin
        if (mode_23) begin
          if (!gate_sync) begin
            counter_out <= 1'b1;
          end else if (!gate_d && !null_count) begin
            load_pending <= 1'b1;
          end
        end
        if (count_edge && !halt) begin
          if (load_pending && !write_counter && mode_ok) begin
            count        <= count_reg;
            load_pending <= 1'b0;
            null_count   <= 1'b0;
          end else if (!null_count && gate_sync) begin
            case (mode)
              MODE_0: begin
                count <= dec1;
                if (dec1 == COUNT_ZERO) counter_out <= 1'b1;
              end
              MODE_2: begin
                if (count == COUNT_ONE) begin
                  count       <= count_reg;
                  counter_out <= 1'b1;
                end else begin
                  count <= dec1;
                  if (dec1 == COUNT_ONE) counter_out <= 1'b0;
                end
              end
              MODE_3: begin
                if (m3_zero) begin
                  count       <= count_reg;
                  counter_out <= ~counter_out;
                end else begin
                  count <= m3_next;
                end
              end
              MODE_4: begin
                count       <= dec1;
                counter_out <= (dec1 != COUNT_ZERO);
              end
              default: ;
            endcase
          end
        end
        if (write_counter) begin
          case (rw)
            RW_LSB: begin
              count_reg    <= {8'h00, internal_data_bus};
              load_pending <= 1'b1;
            end
            RW_MSB: begin
              count_reg    <= {internal_data_bus, 8'h00};
              load_pending <= 1'b1;
            end
            RW_BOTH: begin
              if (wr_ptr == PTR_LSB) begin
                count_reg[7:0] <= internal_data_bus;
                wr_ptr         <= PTR_MSB;
                if (mode == MODE_0) counter_out <= 1'b0;
              end else begin
                count_reg[15:8] <= internal_data_bus;
                wr_ptr          <= PTR_LSB;
                load_pending    <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output latch and read byte pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latch          <= 16'h0000;
      latched        <= 1'b0;
      rd_ptr         <= PTR_LSB;
      read_counter_d <= 1'b0;
    end else begin
      read_counter_d <= read_counter;
      if (write_control) begin
        if (cw_rw == RW_LATCH) begin
          if (!latched) begin
            latch   <= count;
            latched <= 1'b1;
          end
        end else begin
          latched <= 1'b0;
          rd_ptr  <= PTR_LSB;
        end
      end else if (read_fall) begin
        if ((rw == RW_BOTH) && (rd_ptr == PTR_LSB)) begin
          rd_ptr <= PTR_MSB;
        end else begin
          rd_ptr  <= PTR_LSB;
          latched <= 1'b0;
        end
      end
    end
  end

  // Read byte selection from latch or live count
  logic [15:0] rd_src;
  always_comb begin
    rd_src = latched ? latch : count;
    case (rw)
      RW_MSB:  read_data = rd_src[15:8];
      RW_BOTH: read_data = (rd_ptr == PTR_MSB) ? rd_src[15:8] : rd_src[7:0];
      default: read_data = rd_src[7:0];
    endcase
  end

endmodule
